// File: rtl/store_buffer.sv
// Store buffer: zero-wait stores queued in a FIFO and drained to data memory.
// Optional load bypass of non-matching buffered stores: STORE_BUFFER_LOAD_BYPASS_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic [3:0]  cpu_sign_mask,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, RESP
  } state_t;

  state_t state, state_nx;

  logic [31:0]   buf_addr [DEPTH];
  logic [31:0]   buf_data [DEPTH];
  logic [3:0]    buf_mask [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic full, push, pop, load_ok;

  assign full = (count == CW'(DEPTH));
  assign pop  = (state == WAIT_WR) && !mem_busy;
  // A full buffer accepts the held store in the same cycle a slot frees.
  assign push = cpu_memwrite && (!full || pop);

  assign cpu_stall = (cpu_memwrite && full && !pop) ||
                     (cpu_memread && (state != RESP));

  assign mem_memwrite = (state == ISSUE_WR);
  assign mem_memread  = (state == ISSUE_RD);

`ifdef STORE_BUFFER_LOAD_BYPASS_EN
  logic          hit;
  logic [PW-1:0] off;

  // Word-address match of the load against every occupied entry.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ((CW'(off) < count) &&
          (buf_addr[i][31:2] == cpu_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign load_ok = cpu_memread && ((count == '0) || !hit);
`else
  assign load_ok = cpu_memread && (count == '0);
`endif

  // Control FSM next state; loads win over drains in IDLE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load_ok)
          state_nx = ISSUE_RD;
        else if ((count != '0) && !mem_busy)
          state_nx = ISSUE_WR;
      end
      ISSUE_WR: state_nx = WAIT_WR;
      WAIT_WR:  if (!mem_busy) state_nx = IDLE;
      ISSUE_RD: state_nx = WAIT_RD;
      WAIT_RD:  if (!mem_busy) state_nx = RESP;
      RESP:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        buf_addr[wr_ptr] <= cpu_addr;
        buf_data[wr_ptr] <= cpu_write_data;
        buf_mask[wr_ptr] <= cpu_sign_mask;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Memory request fields, latched on issue and held afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
    end else if (state == IDLE && state_nx == ISSUE_WR) begin
      mem_addr       <= buf_addr[rd_ptr];
      mem_write_data <= buf_data[rd_ptr];
      mem_sign_mask  <= buf_mask[rd_ptr];
    end else if (state == IDLE && state_nx == ISSUE_RD) begin
      mem_addr      <= cpu_addr;
      mem_sign_mask <= cpu_sign_mask;
    end
  end

  // Load result captured when the memory read completes.
  always_ff @(posedge clk) begin
    if (reset)
      cpu_read_data <= '0;
    else if (state == WAIT_RD && !mem_busy)
      cpu_read_data <= mem_read_data;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small busy-pulsing memory model.
// Event log records every memory request in issue order.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_write_data = '0;
  logic [3:0]  cpu_sign_mask = '0;
  logic        cpu_memwrite = 1'b0;
  logic        cpu_memread = 1'b0;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_read_data = '0;
  logic        mem_busy;

  int errors = 0;
  int checks = 0;

  logic hold_busy = 1'b0;
  int   busy_cnt = 0;
  bit [31:0] mem_arr [64];
  bit [63:0] wr_seen = '0;
  int          ev_op [$];
  logic [31:0] ev_addr [$];
  logic [31:0] ev_data [$];

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_sign_mask(cpu_sign_mask),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_sign_mask(mem_sign_mask),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_read_data(mem_read_data), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  assign mem_busy = hold_busy | (busy_cnt != 0);

  // Memory model: two busy cycles after every request.
  always @(posedge clk) begin
    if (mem_memwrite) begin
      ev_op.push_back(1);
      ev_addr.push_back(mem_addr);
      ev_data.push_back(mem_write_data);
      mem_arr[mem_addr[7:2]] <= mem_write_data;
      wr_seen[mem_addr[7:2]] <= 1'b1;
      busy_cnt <= 2;
    end else if (mem_memread) begin
      ev_op.push_back(2);
      ev_addr.push_back(mem_addr);
      ev_data.push_back(32'h0);
      mem_read_data <= wr_seen[mem_addr[7:2]] ?
                       mem_arr[mem_addr[7:2]] :
                       (mem_addr ^ 32'h5A5A_0000);
      busy_cnt <= 2;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic clear_log();
    ev_op.delete();
    ev_addr.delete();
    ev_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL rst_stall got=%b exp=0", cpu_stall);
    end
    checks++;
    if ({mem_memwrite, mem_memread} !== 2'b00) begin
      errors++; $display("FAIL rst_memrw got=%b%b exp=00", mem_memwrite, mem_memread);
    end
    checks++;
    if ({mem_addr, mem_write_data, mem_sign_mask} !== 68'h0) begin
      errors++; $display("FAIL rst_memfields got=%h/%h/%h exp=0", mem_addr, mem_write_data, mem_sign_mask);
    end
    checks++;
    if (cpu_read_data !== 32'h0) begin
      errors++; $display("FAIL rst_rdata got=%h exp=0", cpu_read_data);
    end
    checks++;
    if (dut.count !== 3'd0) begin
      errors++; $display("FAIL rst_count got=%0d exp=0", dut.count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_store();
    int k;
    clear_log();
    cpu_addr = 32'h1004; cpu_write_data = 32'hDEADBEEF;
    cpu_sign_mask = 4'h7; cpu_memwrite = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL st1_stall got=%b exp=0", cpu_stall);
    end
    @(negedge clk);
    cpu_memwrite = 1'b0;
    k = 0;
    while (mem_memwrite !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    checks++;
    if (mem_memwrite !== 1'b1) begin
      errors++; $display("FAIL st1_issue timeout got=%b exp=1", mem_memwrite);
    end
    checks++;
    if ({mem_addr, mem_write_data, mem_sign_mask} !== {32'h1004, 32'hDEADBEEF, 4'h7}) begin
      errors++; $display("FAIL st1_fields got=%h/%h/%h exp=1004/deadbeef/7", mem_addr, mem_write_data, mem_sign_mask);
    end
    @(negedge clk);
    checks++;
    if (mem_memwrite !== 1'b0) begin
      errors++; $display("FAIL st1_pulse got=%b exp=0", mem_memwrite);
    end
    checks++;
    if (mem_addr !== 32'h1004) begin
      errors++; $display("FAIL st1_hold got=%h exp=1004", mem_addr);
    end
    k = 0;
    while (dut.count !== 3'd0 && k < 20) begin
      @(negedge clk); k++;
    end
    checks++;
    if (dut.count !== 3'd0) begin
      errors++; $display("FAIL st1_count got=%0d exp=0", dut.count);
    end
    checks++;
    if (ev_op.size() !== 1) begin
      errors++; $display("FAIL st1_nwrites got=%0d exp=1", ev_op.size());
    end
  endtask

  task automatic test_full_stall();
    int k;
    clear_log();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 32'h1000 + 32'(4 * i);
      cpu_write_data = 32'hA0 + 32'(i);
      cpu_sign_mask = 4'hF; cpu_memwrite = 1'b1;
      #1;
      checks++;
      if (cpu_stall !== 1'b0) begin
        errors++; $display("FAIL full_nostall%0d got=%b exp=0", i, cpu_stall);
      end
      @(negedge clk);
    end
    cpu_addr = 32'h1010; cpu_write_data = 32'hA4;
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++;
      if (cpu_stall !== 1'b1) begin
        errors++; $display("FAIL full_stall%0d got=%b exp=1", j, cpu_stall);
      end
      @(negedge clk);
    end
    hold_busy = 1'b0;
    k = 0;
    while (cpu_stall === 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL full_release timeout got=%b exp=0", cpu_stall);
    end
    checks++;
    if (ev_op.size() !== 1) begin
      errors++; $display("FAIL full_release_at got=%0d writes exp=1", ev_op.size());
    end
    @(negedge clk);
    cpu_memwrite = 1'b0;
    k = 0;
    while ((ev_op.size() < 5 || dut.count !== 3'd0) && k < 100) begin
      @(negedge clk); k++;
    end
    checks++;
    if (ev_op.size() !== 5) begin
      errors++; $display("FAIL full_nwrites got=%0d exp=5", ev_op.size());
    end
    for (int i = 0; i < 5 && i < ev_op.size(); i++) begin
      checks++;
      if ({ev_addr[i], ev_data[i]} !== {32'h1000 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
        errors++;
        $display("FAIL full_order%0d got=%h/%h exp=%h/%h", i, ev_addr[i], ev_data[i], 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_load_after_store();
    int k;
    clear_log();
    cpu_addr = 32'h1008; cpu_write_data = 32'h12345678;
    cpu_sign_mask = 4'hF; cpu_memwrite = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL ld_store_stall got=%b exp=0", cpu_stall);
    end
    @(negedge clk);
    cpu_memwrite = 1'b0; cpu_memread = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL ld_stall_first got=%b exp=1", cpu_stall);
    end
    k = 0;
    while (cpu_stall === 1'b1 && k < 50) begin
      @(negedge clk); k++;
    end
    checks++;
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL ld_resp timeout got=%b exp=0", cpu_stall);
    end
    checks++;
    if (cpu_read_data !== 32'h12345678) begin
      errors++; $display("FAIL ld_rdata got=%h exp=12345678", cpu_read_data);
    end
    checks++;
    if (ev_op.size() !== 2 || ev_op[0] !== 1 || ev_op[1] !== 2) begin
      errors++; $display("FAIL ld_order got=%0d events first=%0d exp=2 events W then R", ev_op.size(), ev_op.size() > 0 ? ev_op[0] : 0);
    end
    @(negedge clk);
    cpu_memread = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (ev_op.size() !== 2) begin
      errors++; $display("FAIL ld_norepeat got=%0d events exp=2", ev_op.size());
    end
  endtask

  task automatic test_bypass();
    int k;
    int exp_first;
    clear_log();
    hold_busy = 1'b1;
    cpu_sign_mask = 4'hF; cpu_memwrite = 1'b1;
    cpu_addr = 32'h1000; cpu_write_data = 32'h11;
    @(negedge clk);
    cpu_addr = 32'h1004; cpu_write_data = 32'h22;
    @(negedge clk);
    cpu_memwrite = 1'b0; cpu_memread = 1'b1; cpu_addr = 32'h1020;
    repeat (3) @(negedge clk);
    hold_busy = 1'b0;
    k = 0;
    while (cpu_stall === 1'b1 && k < 50) begin
      @(negedge clk); k++;
    end
    checks++;
    if (cpu_read_data !== 32'h5A5A1020) begin
      errors++; $display("FAIL byp_rdata got=%h exp=5a5a1020", cpu_read_data);
    end
    @(negedge clk);
    cpu_memread = 1'b0;
    k = 0;
    while ((ev_op.size() < 3 || dut.count !== 3'd0) && k < 50) begin
      @(negedge clk); k++;
    end
`ifdef STORE_BUFFER_LOAD_BYPASS_EN
    exp_first = 2;
`else
    exp_first = 1;
`endif
    checks++;
    if (ev_op.size() !== 3 || ev_op[0] !== exp_first) begin
      errors++; $display("FAIL byp_order got=%0d events first=%0d exp=3 events first=%0d", ev_op.size(), ev_op.size() > 0 ? ev_op[0] : 0, exp_first);
    end
  endtask

  task automatic test_reset_midflight();
    int k;
    hold_busy = 1'b1;
    cpu_sign_mask = 4'hF; cpu_memwrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr = 32'h2000 + 32'(4 * i);
      cpu_write_data = 32'hB0 + 32'(i);
      @(negedge clk);
    end
    cpu_memwrite = 1'b0;
    clear_log();
    hold_busy = 1'b0;
    k = 0;
    while (mem_memwrite !== 1'b1 && k < 20) begin
      @(negedge clk); k++;
    end
    @(negedge clk);
    checks++;
    if (dut.state !== 3'd2 || dut.count !== 3'd3) begin
      errors++; $display("FAIL rmf_pre got state=%0d count=%0d exp state=2 count=3", dut.state, dut.count);
    end
    reset = 1'b1;
    cpu_memwrite = 1'b1; cpu_addr = 32'h3000; cpu_write_data = 32'hFF;
    @(negedge clk);
    cpu_memwrite = 1'b0;
    #1;
    checks++;
    if (dut.count !== 3'd0 || dut.state !== 3'd0) begin
      errors++; $display("FAIL rmf_state got state=%0d count=%0d exp 0/0", dut.state, dut.count);
    end
    checks++;
    if ({cpu_stall, mem_memwrite, mem_memread} !== 3'b000) begin
      errors++; $display("FAIL rmf_ctrl got=%b%b%b exp=000", cpu_stall, mem_memwrite, mem_memread);
    end
    checks++;
    if ({mem_addr, mem_write_data, mem_sign_mask, cpu_read_data} !== 100'h0) begin
      errors++; $display("FAIL rmf_data got=%h/%h/%h/%h exp=0", mem_addr, mem_write_data, mem_sign_mask, cpu_read_data);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ev_op.size() !== 1 || dut.count !== 3'd0) begin
      errors++; $display("FAIL rmf_after got=%0d writes count=%0d exp=1 writes count=0", ev_op.size(), dut.count);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_full_stall();
    test_load_after_store();
    test_bypass();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
